imem_boot_sequencer: RTL and testbench
======================================

// Module: imem_boot_sequencer
// PURPOSE
//  Owns the instruction-RAM port at boot. Accepts program words on a valid/ready stream and
//  writes them to IRAM from word address 0, holding the CPU in reset. After the last word it
//  hands the IRAM port to the CPU, enables IRAM output, then releases CPU reset.
//  Sits between the MIPS_CPU instruction port and the IRAM instance. Replaces bench-side override muxing.
// PARAMETERS
//  DEPTH      1024  IRAM depth in 32-bit words; loader addresses 0..DEPTH-1
//  AW         10    loader address/count width, >= clog2(DEPTH)
//  RUN_DELAY  4     cycles between port handover (boot_done=1) and cpu_reset deassertion, >= 1
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  reset       in   1   asynchronous, active-low; 0 = reset
//  ld_valid    in   1   program word offered
//  ld_data     in   32  program word
//  ld_last     in   1   qualifies the final word (sampled with ld_valid&ld_ready)
//  ld_ready    out  1   sequencer can accept a word this cycle
//  cpu_iaddr   in   32  CPU instruction address (word address)
//  cpu_iread   in   1   CPU instruction read enable
//  cpu_iwrite  in   1   CPU instruction write strobe, active-low
//  cpu_inst    out  32  instruction to CPU = mem_data in RUN, 0 otherwise
//  cpu_reset   out  1   CPU reset, active-high
//  mem_addr    out  32  IRAM address
//  mem_data    inout 32 IRAM data; driven only while a loader write is in SETUP/STROBE/RELEASE, else Z
//  mem_read    out  1   IRAM read enable
//  mem_write   out  1   IRAM write strobe, active-low
//  mem_oe      out  1   IRAM output enable
//  boot_done   out  1   port handed to CPU
//  ld_count    out  AW+1 words written (including fill), saturates at DEPTH
//  err_ovf     out  1   sticky: DEPTH words written without ld_last
// BEHAVIOUR
//  Reset values: ld_ready=0, cpu_reset=1, mem_write=1, mem_read=1, mem_oe=0, mem_addr=0,
//   mem_data=Z, boot_done=0, ld_count=0, err_ovf=0, state=IDLE. Reset mid-load aborts
//   immediately to IDLE; partially written IRAM contents are left unchanged; load restarts at address 0.
//  States: IDLE -> SETUP -> STROBE -> RELEASE -> (IDLE | FILL_SETUP | HANDOVER) ; HANDOVER -> RUN.
//  IDLE: ld_ready=1 (registered; first high one cycle after reset release). Handshake
//   ld_valid&ld_ready captures ld_data/ld_last, ld_ready drops next cycle -> SETUP.
//  SETUP: mem_addr=wptr, mem_data=word, mem_write=1 (address/data setup cycle).
//  STROBE: mem_write=0 for exactly one cycle, addr/data held.
//  RELEASE: mem_write=1, addr/data held; wptr+1, ld_count+1. Next: ld_last -> fill or HANDOVER;
//   wptr==DEPTH (DEPTH words written) without last -> err_ovf=1, treat as last; else IDLE.
//  Throughput: one word per 4 cycles with ld_valid held high.
//  HANDOVER: boot_done=1, mem_oe=1; mem_addr/mem_read/mem_write become combinational
//   pass-through of cpu_iaddr/cpu_iread/cpu_iwrite; counter runs RUN_DELAY cycles, then cpu_reset=0 -> RUN.
//  RUN: terminal until reset. ld_ready=0, ld_valid ignored, ld_count/err_ovf frozen.
//  ld_last on first word: single-word program, legal. ld_valid without ld_last after ovf: ignored.
//  ld_valid low in IDLE: wait indefinitely, cpu_reset stays 1.
// CONFIGURATION
//  IMEM_ZERO_FILL_EN defined: after last word, FILL states write 32'h0 to every address
//   wptr..DEPTH-1 with the same SETUP/STROBE/RELEASE timing (3 cycles/word, ld_ready=0),
//   ld_count reaches DEPTH, then HANDOVER. No fill if already full.
//  Undefined: go straight to HANDOVER; unwritten IRAM words keep prior contents.
// TESTING
//  T1 3 words 8C010000,20220005,AC020004 (last on 3rd), valid held -> IRAM[0..2] match,
//   mem_write low once per word 4 cycles apart, boot_done at cycle 12, cpu_reset=0 RUN_DELAY later.
//  T2 single word with ld_last -> ld_count=1, handover; in RUN cpu_iaddr=0 returns that word on cpu_inst.
//  T3 DEPTH=8, 9 words, no last -> 8 written, err_ovf=1, 9th never accepted (ld_ready stays 0).
//  T4 reset low during STROBE of word 2 -> all outputs at reset values same cycle; reload from addr 0 succeeds.
//  T5 IMEM_ZERO_FILL_EN, DEPTH=16, preload IRAM FFFFFFFF, load 2 words -> IRAM[2..15]=0, ld_count=16.
//  T6 ld_valid toggled 1/0 randomly -> no duplicate or dropped words, mem_data Z whenever not writing.

Source files
------------

// File: rtl/imem_boot_sequencer.sv
// rtl/imem_boot_sequencer.sv - boot loader that writes the program into instruction RAM, then releases the CPU
//
// Purpose
//  Owns the instruction-RAM port while the system boots. Program words arrive on a
//  valid/ready stream. Each word is written to IRAM, starting at word address 0, using
//  three cycles: SETUP, STROBE and RELEASE. The CPU is held in reset for the whole load.
//  After the last word, the IRAM address/read/write pins are handed to the CPU and IRAM
//  output is enabled. CPU reset is released RUN_DELAY cycles after that.
//
// Build option
//  IMEM_ZERO_FILL_EN : when defined, the sequencer writes 32'h0 to every address after the
//                      last loaded word, up to DEPTH-1, before handover. When undefined,
//                      unwritten words keep their previous contents.
//
// Ports
//  clk_i          system clock, rising edge
//  reset_ni       asynchronous active-low reset
//  ld_valid_i     program word offered
//  ld_data_i      program word
//  ld_last_i      marks the final word (sampled on the handshake)
//  ld_ready_o     sequencer accepts a word this cycle
//  cpu_iaddr_i    CPU instruction word address
//  cpu_iread_i    CPU instruction read enable
//  cpu_iwrite_i   CPU instruction write strobe, active-low
//  cpu_inst_o     instruction to CPU: IRAM data once running, else 0
//  cpu_reset_o    CPU reset, active-high
//  mem_addr_o     IRAM address
//  mem_data_io    IRAM data bus; driven only during a loader write
//  mem_read_o     IRAM read enable
//  mem_write_o    IRAM write strobe, active-low
//  mem_oe_o       IRAM output enable
//  boot_done_o    IRAM port handed to the CPU
//  ld_count_o     words written, fill words included; saturates at DEPTH
//  err_ovf_o      sticky: DEPTH words written without ld_last

module imem_boot_sequencer #(
    parameter int DEPTH     = 1024,
    parameter int AW        = 10,
    parameter int RUN_DELAY = 4
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          ld_valid_i,
    input  logic [31:0]   ld_data_i,
    input  logic          ld_last_i,
    output logic          ld_ready_o,
    input  logic [31:0]   cpu_iaddr_i,
    input  logic          cpu_iread_i,
    input  logic          cpu_iwrite_i,
    output logic [31:0]   cpu_inst_o,
    output logic          cpu_reset_o,
    output logic [31:0]   mem_addr_o,
    inout  wire  [31:0]   mem_data_io,
    output logic          mem_read_o,
    output logic          mem_write_o,
    output logic          mem_oe_o,
    output logic          boot_done_o,
    output logic [AW:0]   ld_count_o,
    output logic          err_ovf_o
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_RELEASE,
        ST_FILL_SETUP,
        ST_FILL_STROBE,
        ST_FILL_RELEASE,
        ST_HANDOVER,
        ST_RUN
    } state_t;

    localparam int             CW       = AW + 1;
    localparam int             DW       = (RUN_DELAY < 2) ? 1 : $clog2(RUN_DELAY);
    localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
    localparam logic [DW-1:0]  DLY_LAST = DW'(RUN_DELAY - 1);
    localparam logic [DW-1:0]  DLY_ONE  = DW'(1);

    state_t         state_q;
    logic           ld_ready_q;
    logic           last_q;
    logic [31:0]    word_q;
    logic [AW-1:0]  addr_q;
    logic           drive_q;
    logic           mem_write_q;
    logic           mem_oe_q;
    logic           boot_done_q;
    logic           cpu_reset_q;
    logic [CW-1:0]  cnt_q;
    logic           err_ovf_q;
    logic [DW-1:0]  dly_q;

    // cnt_q is both the write pointer and the count of words written.
    logic [CW-1:0]  cnt_d;
    logic           full_d;
    logic           load_end;
    logic           fill_more;

    assign cnt_d  = cnt_q + {{AW{1'b0}}, 1'b1};
    assign full_d = (cnt_d == DEPTH_C);

    // Loading stops after the last word of the fill, after a word tagged last, or when
    // IRAM is full. A full IRAM without a last tag counts as an overflow but ends the load
    // the same way.
    assign load_end = (state_q == ST_FILL_RELEASE) || last_q || full_d;

`ifdef IMEM_ZERO_FILL_EN
    assign fill_more = !full_d;
`else
    assign fill_more = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            ld_ready_q  <= 1'b0;
            last_q      <= 1'b0;
            word_q      <= '0;
            addr_q      <= '0;
            drive_q     <= 1'b0;
            mem_write_q <= 1'b1;
            mem_oe_q    <= 1'b0;
            boot_done_q <= 1'b0;
            cpu_reset_q <= 1'b1;
            cnt_q       <= '0;
            err_ovf_q   <= 1'b0;
            dly_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ld_ready_q && ld_valid_i) begin
                        word_q     <= ld_data_i;
                        last_q     <= ld_last_i;
                        addr_q     <= cnt_q[AW-1:0];
                        drive_q    <= 1'b1;
                        ld_ready_q <= 1'b0;
                        state_q    <= ST_SETUP;
                    end else begin
                        ld_ready_q <= 1'b1;
                    end
                end

                ST_SETUP, ST_FILL_SETUP: begin
                    mem_write_q <= 1'b0;
                    state_q     <= (state_q == ST_SETUP) ? ST_STROBE : ST_FILL_STROBE;
                end

                ST_STROBE, ST_FILL_STROBE: begin
                    mem_write_q <= 1'b1;
                    state_q     <= (state_q == ST_STROBE) ? ST_RELEASE : ST_FILL_RELEASE;
                end

                ST_RELEASE, ST_FILL_RELEASE: begin
                    cnt_q <= cnt_d;
                    if (state_q == ST_RELEASE && !last_q && full_d) begin
                        err_ovf_q <= 1'b1;
                    end
                    if (!load_end) begin
                        drive_q    <= 1'b0;
                        ld_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else if (fill_more) begin
                        // The bus stays driven. Only the address and data change for the
                        // next zero word.
                        word_q  <= '0;
                        addr_q  <= cnt_d[AW-1:0];
                        state_q <= ST_FILL_SETUP;
                    end else begin
                        drive_q     <= 1'b0;
                        boot_done_q <= 1'b1;
                        mem_oe_q    <= 1'b1;
                        dly_q       <= '0;
                        state_q     <= ST_HANDOVER;
                    end
                end

                ST_HANDOVER: begin
                    if (dly_q == DLY_LAST) begin
                        cpu_reset_q <= 1'b0;
                        state_q     <= ST_RUN;
                    end else begin
                        dly_q <= dly_q + DLY_ONE;
                    end
                end

                ST_RUN: begin
                    state_q <= ST_RUN;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Once the port is handed over, the CPU drives the IRAM control pins directly so that
    // instruction fetch adds no register stage.
    assign mem_addr_o  = boot_done_q ? cpu_iaddr_i  : {{(32-AW){1'b0}}, addr_q};
    assign mem_read_o  = boot_done_q ? cpu_iread_i  : 1'b1;
    assign mem_write_o = boot_done_q ? cpu_iwrite_i : mem_write_q;
    assign mem_oe_o    = mem_oe_q;
    assign mem_data_io = drive_q ? word_q : {32{1'bz}};

    assign cpu_inst_o  = cpu_reset_q ? 32'h0 : mem_data_io;
    assign cpu_reset_o = cpu_reset_q;
    assign boot_done_o = boot_done_q;
    assign ld_ready_o  = ld_ready_q;
    assign ld_count_o  = cnt_q;
    assign err_ovf_o   = err_ovf_q;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// tb/tb_imem_boot_sequencer.sv - scoreboard bench for imem_boot_sequencer
module tb_imem_boot_sequencer;

    localparam int DEPTH     = 8;
    localparam int AW        = 3;
    localparam int RUN_DELAY = 4;
`ifdef IMEM_ZERO_FILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ld_valid = 1'b0;
    logic [31:0]   ld_data = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic [31:0]   cpu_iaddr = '0;
    logic          cpu_iread = 1'b0;
    logic          cpu_iwrite = 1'b1;
    logic [31:0]   cpu_inst;
    logic          cpu_reset;
    logic [31:0]   mem_addr;
    wire  [31:0]   mem_data;
    logic          mem_read;
    logic          mem_write;
    logic          mem_oe;
    logic          boot_done;
    logic [AW:0]   ld_count;
    logic          err_ovf;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            tb_wptr = 0;
    bit            preload = 1'b0;
    wr_t           exp_q[$];
    int            strobe_cyc[$];
    logic [31:0]   iram [DEPTH];

    imem_boot_sequencer #(.DEPTH(DEPTH), .AW(AW), .RUN_DELAY(RUN_DELAY)) dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .ld_valid_i   (ld_valid),
        .ld_data_i    (ld_data),
        .ld_last_i    (ld_last),
        .ld_ready_o   (ld_ready),
        .cpu_iaddr_i  (cpu_iaddr),
        .cpu_iread_i  (cpu_iread),
        .cpu_iwrite_i (cpu_iwrite),
        .cpu_inst_o   (cpu_inst),
        .cpu_reset_o  (cpu_reset),
        .mem_addr_o   (mem_addr),
        .mem_data_io  (mem_data),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .mem_oe_o     (mem_oe),
        .boot_done_o  (boot_done),
        .ld_count_o   (ld_count),
        .err_ovf_o    (err_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // IRAM model: writes on a clock edge while the strobe is low, and drives the bus on reads.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) iram[i] <= 32'hFFFF_FFFF;
        end else if (!mem_write) begin
            iram[mem_addr[AW-1:0]] <= mem_data;
        end
    end
    assign mem_data = (mem_oe && mem_read && mem_write) ? iram[mem_addr[AW-1:0]] : 32'hzzzz_zzzz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every loader write strobe must match the next expected write.
    always @(negedge clk) begin
        if (reset_n && !mem_write && !boot_done) begin
            strobe_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", mem_addr, e.addr);
                chk("write_data", mem_data, e.data);
            end
        end
    end

    task automatic do_reset();
        reset_n  = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        cpu_iread = 1'b0;
        cpu_iwrite = 1'b1;
        cpu_iaddr = '0;
        tb_wptr  = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("rst_ld_ready", 32'(ld_ready), 32'h0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("rst_mem_write", 32'(mem_write), 32'h1);
        chk("rst_mem_read", 32'(mem_read), 32'h1);
        chk("rst_mem_oe", 32'(mem_oe), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_boot_done", 32'(boot_done), 32'h0);
        chk("rst_ld_count", 32'(ld_count), 32'h0);
        chk("rst_err_ovf", 32'(err_ovf), 32'h0);
        reset_n = 1'b1;
        #1 chk("ready_after_release", 32'(ld_ready), 32'h0);
        @(negedge clk);
        chk("ready_one_cycle_later", 32'(ld_ready), 32'h1);
    endtask

    task automatic send(input logic [31:0] d, input logic last, input bit rnd, output int hs);
        int n;
        n = 0;
        hs = -1;
        ld_data = d;
        ld_last = last;
        forever begin
            @(negedge clk);
            ld_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (ld_valid && ld_ready) break;
            n++;
            if (n > 60) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no handshake, expected one within 60 cycles");
                ld_valid = 1'b0;
                return;
            end
        end
        hs = cyc;
        exp_q.push_back('{addr: 32'(tb_wptr), data: d});
        tb_wptr++;
        if (last && FILL) begin
            while (tb_wptr < DEPTH) begin
                exp_q.push_back('{addr: 32'(tb_wptr), data: 32'h0});
                tb_wptr++;
            end
        end
        @(posedge clk);
        #1 ld_valid = 1'b0;
    endtask

    task automatic wait_evt(input string name, input bit want_boot, output int c);
        int n;
        n = 0;
        c = -1;
        forever begin
            @(negedge clk);
            if (want_boot ? boot_done : !cpu_reset) begin
                c = cyc;
                return;
            end
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL %s: got no event, expected one within 200 cycles", name);
                return;
            end
        end
    endtask

    initial begin
        int hs0, hs, cb, cr, nrdy, s0;
        logic [31:0] w6 [5];

        // Start with IRAM preloaded with all ones.
        preload = 1'b1;
        @(posedge clk);
        #1 preload = 1'b0;

        // T1: three words, valid held, last on the third word.
        do_reset();
        strobe_cyc.delete();
        send(32'h8C01_0000, 1'b0, 1'b0, hs0);
        send(32'h2022_0005, 1'b0, 1'b0, hs);
        send(32'hAC02_0004, 1'b1, 1'b0, hs);
        wait_evt("t1_boot", 1'b1, cb);
        chk("t1_boot_cycle", 32'(cb - hs0), 32'(12 + (FILL ? 3 * (DEPTH - 3) : 0)));
        wait_evt("t1_run", 1'b0, cr);
        chk("t1_run_delay", 32'(cr - cb), 32'(RUN_DELAY));
        if (strobe_cyc.size() >= 3) begin
            chk("t1_strobe0", 32'(strobe_cyc[0] - hs0), 32'd2);
            chk("t1_strobe_gap1", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd4);
            chk("t1_strobe_gap2", 32'(strobe_cyc[2] - strobe_cyc[1]), 32'd4);
        end else begin
            chk("t1_strobe_count", 32'(strobe_cyc.size()), 32'd3);
        end
        chk("t1_iram0", iram[0], 32'h8C01_0000);
        chk("t1_iram1", iram[1], 32'h2022_0005);
        chk("t1_iram2", iram[2], 32'hAC02_0004);
        chk("t1_ld_count", 32'(ld_count), FILL ? 32'(DEPTH) : 32'd3);
        chk("t1_err_ovf", 32'(err_ovf), 32'h0);
        cpu_iaddr = 32'd1;
        cpu_iread = 1'b1;
        #1;
        chk("t1_cpu_inst", cpu_inst, 32'h2022_0005);
        chk("t1_addr_pass", mem_addr, 32'd1);
        chk("t1_mem_oe", 32'(mem_oe), 32'h1);
        cpu_iread = 1'b0;
        #1 chk("t1_read_pass", 32'(mem_read), 32'h0);
        // Words offered in RUN must be ignored.
        ld_valid = 1'b1;
        ld_last = 1'b1;
        nrdy = 0;
        repeat (6) begin
            @(negedge clk);
            if (ld_ready) nrdy++;
        end
        ld_valid = 1'b0;
        chk("t1_run_no_ready", 32'(nrdy), 32'd0);
        chk("t1_run_count_frozen", 32'(ld_count), FILL ? 32'(DEPTH) : 32'd3);

        // T2: a single word tagged last.
        do_reset();
        send(32'h1234_5678, 1'b1, 1'b0, hs);
        wait_evt("t2_boot", 1'b1, cb);
        chk("t2_ld_count", 32'(ld_count), FILL ? 32'(DEPTH) : 32'd1);
        cpu_iaddr = 32'd0;
        cpu_iread = 1'b1;
        #1 chk("t2_inst_zero_in_handover", cpu_inst, 32'h0);
        wait_evt("t2_run", 1'b0, cr);
        chk("t2_cpu_inst0", cpu_inst, 32'h1234_5678);
        cpu_iaddr = 32'd1;
        #1 chk("t2_cpu_inst1", cpu_inst, FILL ? 32'h0 : 32'h2022_0005);
        cpu_iread = 1'b0;

        // T3: DEPTH words with no last tag, then one more word is offered.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            send(32'hA000_0000 + 32'(i), 1'b0, 1'b0, hs);
            if (i == DEPTH - 2) chk("t3_no_ovf_yet", 32'(err_ovf), 32'h0);
        end
        ld_data = 32'h0000_0BAD;
        ld_last = 1'b0;
        ld_valid = 1'b1;
        nrdy = 0;
        repeat (30) begin
            @(negedge clk);
            if (ld_ready) nrdy++;
        end
        ld_valid = 1'b0;
        chk("t3_ninth_refused", 32'(nrdy), 32'd0);
        chk("t3_err_ovf", 32'(err_ovf), 32'h1);
        chk("t3_ld_count", 32'(ld_count), 32'(DEPTH));
        chk("t3_boot_done", 32'(boot_done), 32'h1);
        chk("t3_iram_last", iram[DEPTH-1], 32'hA000_0007);

        // T4: reset asserted during the strobe of the second word.
        do_reset();
        send(32'h1111_1111, 1'b0, 1'b0, hs);
        send(32'h2222_2222, 1'b0, 1'b0, hs);
        s0 = 0;
        while (mem_write && s0 < 10) begin
            @(negedge clk);
            s0++;
        end
        #2 reset_n = 1'b0;
        #1;
        chk("t4_mem_write", 32'(mem_write), 32'h1);
        chk("t4_ld_ready", 32'(ld_ready), 32'h0);
        chk("t4_mem_addr", mem_addr, 32'h0);
        chk("t4_ld_count", 32'(ld_count), 32'h0);
        chk("t4_cpu_reset", 32'(cpu_reset), 32'h1);
        @(negedge clk);
        chk("t4_iram1_untouched", iram[1], 32'hA000_0001);
        do_reset();
        send(32'h3333_3333, 1'b0, 1'b0, hs);
        send(32'h4444_4444, 1'b1, 1'b0, hs);
        wait_evt("t4_boot", 1'b1, cb);
        chk("t4_iram0", iram[0], 32'h3333_3333);
        chk("t4_iram1", iram[1], 32'h4444_4444);
        chk("t4_reload_count", 32'(ld_count), FILL ? 32'(DEPTH) : 32'd2);

        // T5: fill behaviour over a preloaded IRAM.
        preload = 1'b1;
        @(posedge clk);
        #1 preload = 1'b0;
        do_reset();
        send(32'hCAFE_0001, 1'b0, 1'b0, hs);
        send(32'hCAFE_0002, 1'b1, 1'b0, hs);
        wait_evt("t5_boot", 1'b1, cb);
        chk("t5_ld_count", 32'(ld_count), FILL ? 32'(DEPTH) : 32'd2);
        for (int i = 2; i < DEPTH; i++) begin
            chk($sformatf("t5_iram%0d", i), iram[i], FILL ? 32'h0 : 32'hFFFF_FFFF);
        end

        // T6: valid toggled randomly.
        do_reset();
        strobe_cyc.delete();
        w6[0] = 32'h6000_0011;
        w6[1] = 32'h6000_0022;
        w6[2] = 32'h6000_0033;
        w6[3] = 32'h6000_0044;
        w6[4] = 32'h6000_0055;
        for (int i = 0; i < 5; i++) begin
            send(w6[i], (i == 4), 1'b1, hs);
        end
        wait_evt("t6_boot", 1'b1, cb);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t6_iram%0d", i), iram[i], w6[i]);
        end
        chk("t6_strobes", 32'(strobe_cyc.size()), FILL ? 32'(DEPTH) : 32'd5);
        chk("t6_ld_count", 32'(ld_count), FILL ? 32'(DEPTH) : 32'd5);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

endmodule
